// File: rtl/case_edge_qualifier_pkg.sv
// Shared definitions for the case-decoder edge qualifier: FSM state
// encodings and a constant-width helper.
package case_edge_pkg;

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] CHK_HI  = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] CHK_LO  = 2'd3;

  // Ceiling log2, clamped to at least 1 so it can size a vector.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/case_edge_qualifier_sync2.sv
// Two-flop synchronizer bringing the asynchronous decoder output into clk.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // Shift d through two flops; both clear to 0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/case_edge_qualifier.sv
// Registered checker stage behind the case decoder: synchronizes foo_in,
// accepts a level change only after STABLE consecutive cycles, emits
// one-cycle rise/fall pulses and counts accepted rises (saturating).
module case_edge_qualifier
  import case_edge_pkg::*;
#(
  parameter int unsigned STABLE = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             foo_in,
  input  logic             clr,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat
);

  localparam int unsigned        RUN_W    = clog2(STABLE);
  localparam logic [RUN_W-1:0]   RUN_LAST = RUN_W'(STABLE - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  logic             s2;
  logic [1:0]       state, state_n;
  logic [RUN_W-1:0] run, run_n;
  logic             acc_rise, acc_fall;
  logic [CNT_W-1:0] cnt_inc;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (foo_in),
    .q     (s2)
  );

  // Next-state and acceptance decode; only the synchronized s2 is observed.
  always_comb begin
    state_n  = state;
    run_n    = run;
    acc_rise = 1'b0;
    acc_fall = 1'b0;
    case (state)
      IDLE_LO: begin
        if (s2) begin
          state_n = CHK_HI;
          run_n   = RUN_W'(1);
        end
      end
      CHK_HI: begin
        if (!s2) begin
          state_n = IDLE_LO;
          run_n   = '0;
        end else if (run == RUN_LAST) begin
          state_n  = IDLE_HI;
          run_n    = '0;
          acc_rise = 1'b1;
        end else begin
          run_n = run + RUN_W'(1);
        end
      end
      IDLE_HI: begin
        if (!s2) begin
          state_n = CHK_LO;
          run_n   = RUN_W'(1);
        end
      end
      CHK_LO: begin
        if (s2) begin
          state_n = IDLE_HI;
          run_n   = '0;
        end else if (run == RUN_LAST) begin
          state_n  = IDLE_LO;
          run_n    = '0;
          acc_fall = 1'b1;
        end else begin
          run_n = run + RUN_W'(1);
        end
      end
      default: begin
        state_n = IDLE_LO;
        run_n   = '0;
      end
    endcase
  end

  // FSM, run counter, qualified level and single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE_LO;
      run        <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      run        <= run_n;
      rise_pulse <= acc_rise;
      fall_pulse <= acc_fall;
      if (acc_rise)      level_out <= 1'b1;
      else if (acc_fall) level_out <= 1'b0;
    end
  end

  assign cnt_inc = edge_cnt + CNT_W'(1);

  // Saturating rise counter; clr takes priority over a same-edge rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else if (clr) begin
      edge_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else if (acc_rise && (edge_cnt != CNT_MAX)) begin
      edge_cnt <= cnt_inc;
      cnt_sat  <= (cnt_inc == CNT_MAX);
    end
  end

endmodule

// File: tb/tb_case_edge_qualifier.sv
// Directed bench for case_edge_qualifier (STABLE=3, CNT_W=4). Stimulus pushes
// the expected pulse (with its edge number) into a queue; a monitor pops and
// compares whenever the DUT shows a rise or fall pulse.
module tb_case_edge_qualifier;

  localparam int unsigned ST = 3;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic          rise;
    logic          fall;
    logic          lvl;
    logic [CW-1:0] cnt;
    logic          sat;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bit_in = 1'b0;
  logic          foo;
  logic          clr = 1'b0;
  logic          level_out, rise_pulse, fall_pulse, cnt_sat;
  logic [CW-1:0] edge_cnt;

  exp_t exp_q[$];
  int   cyc = 0;
  int   ntests = 0;
  int   nfail = 0;

  // Case-decoder model: empty 1'b0 arm, default 0.
  always_comb begin
    foo = 1'b0;
    case (bit_in)
      1'b0: ;
      1'b1: foo = 1'b1;
      default: foo = 1'b0;
    endcase
  end

  case_edge_qualifier #(.STABLE(ST), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .foo_in     (foo),
    .clr        (clr),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .edge_cnt   (edge_cnt),
    .cnt_sat    (cnt_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the next queued expectation, including its edge.
  always @(negedge clk) begin
    if (rst_n && (rise_pulse || fall_pulse)) begin
      ntests++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_pulse: got rise=%0b fall=%0b at edge %0d, expected none",
                 rise_pulse, fall_pulse, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({rise_pulse, fall_pulse, level_out, edge_cnt, cnt_sat} !== {e.rise, e.fall, e.lvl, e.cnt, e.sat}
            || cyc != e.cyc) begin
          nfail++;
          $display("FAIL pulse: got r=%0b f=%0b l=%0b cnt=%0d sat=%0b edge=%0d expected r=%0b f=%0b l=%0b cnt=%0d sat=%0b edge=%0d",
                   rise_pulse, fall_pulse, level_out, edge_cnt, cnt_sat, cyc,
                   e.rise, e.fall, e.lvl, e.cnt, e.sat, e.cyc);
        end
      end
    end
  end

  // Raise bit_in, expect the rise STABLE+2 edges later; optionally assert clr on that edge.
  task automatic do_rise(input logic use_clr, input logic [CW-1:0] c, input logic s);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    n = cyc;
    bit_in = 1'b1;
    e = '{rise: 1'b1, fall: 1'b0, lvl: 1'b1, cnt: c, sat: s, cyc: n + ST + 2};
    exp_q.push_back(e);
    if (use_clr) begin
      repeat (ST + 1) @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      repeat (3) @(posedge clk);
    end else begin
      repeat (8) @(posedge clk);
    end
  endtask

  task automatic do_fall(input logic [CW-1:0] c, input logic s);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    n = cyc;
    bit_in = 1'b0;
    e = '{rise: 1'b0, fall: 1'b1, lvl: 1'b0, cnt: c, sat: s, cyc: n + ST + 2};
    exp_q.push_back(e);
    repeat (8) @(posedge clk);
  endtask

  initial begin
    int m;
    exp_t e;
    // Reset state
    #2;
    chk("rst_level", 32'(level_out), 0);
    chk("rst_rise", 32'(rise_pulse), 0);
    chk("rst_fall", 32'(fall_pulse), 0);
    chk("rst_cnt", 32'(edge_cnt), 0);
    chk("rst_sat", 32'(cnt_sat), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle low for 20 cycles
    repeat (20) @(posedge clk);
    #1;
    chk("idle_level", 32'(level_out), 0);
    chk("idle_cnt", 32'(edge_cnt), 0);

    // First qualified rise and fall
    do_rise(1'b0, 4'd1, 1'b0);
    chk("hold_level", 32'(level_out), 1);
    do_fall(4'd1, 1'b0);

    // Clear, then a 2-cycle glitch must be rejected
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    chk("clr_cnt", 32'(edge_cnt), 0);
    bit_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 bit_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("glitch_level", 32'(level_out), 0);
    chk("glitch_cnt", 32'(edge_cnt), 0);

    // Saturation: 16 rises, counter stops at 15
    for (int i = 1; i <= 16; i++) begin
      do_rise(1'b0, (i < 15) ? CW'(i) : 4'd15, (i >= 15));
      do_fall((i < 15) ? CW'(i) : 4'd15, (i >= 15));
    end
    chk("sat_cnt", 32'(edge_cnt), 15);
    chk("sat_flag", 32'(cnt_sat), 1);

    // Reset while in CHK_HI with foo_in held high
    @(posedge clk); #1;
    bit_in = 1'b1;
    repeat (ST) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_level", 32'(level_out), 0);
    chk("midrst_rise", 32'(rise_pulse), 0);
    chk("midrst_cnt", 32'(edge_cnt), 0);
    chk("midrst_sat", 32'(cnt_sat), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m = cyc;
    e = '{rise: 1'b1, fall: 1'b0, lvl: 1'b1, cnt: 4'd1, sat: 1'b0, cyc: m + ST + 2};
    exp_q.push_back(e);
    repeat (8) @(posedge clk);
    do_fall(4'd1, 1'b0);

    // clr on the same edge as an accepted rise with edge_cnt=7
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      do_rise(1'b0, CW'(i), 1'b0);
      do_fall(CW'(i), 1'b0);
    end
    do_rise(1'b1, 4'd0, 1'b0);
    chk("clr_rise_level", 32'(level_out), 1);
    do_fall(4'd0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    nfail++;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $fatal(1);
  end

endmodule
